// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
// The geometry helpers keep the address split in one place for the top and the line store.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } dc_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_W     = 256;
  localparam int WORDS_PER_LINE = DEF_LINE_W / DEF_DATA_W;

  function automatic int calc_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int line_w, input int num_lines);
    return addr_w - calc_idx_w(num_lines) - calc_off_w(line_w);
  endfunction

  function automatic int calc_words(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

  // Word-select width never drops below one bit so ports stay legal when a line holds one word.
  function automatic int calc_wsel_w(input int line_w, input int data_w);
    return (calc_words(line_w, data_w) > 1) ? $clog2(calc_words(line_w, data_w)) : 1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid, dirty and data arrays of the cache: one combinational read port,
// one synchronous write port (word merge or full-line install) and a synchronous valid/dirty clear.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 22,
  parameter int IDX_W     = 5,
  parameter int WSEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_word_i,
  input  logic              wr_line_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_wsel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_fill_i
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [LINE_W-1:0]    line_d;

  always_comb begin
    rd_tag_o   = tag_q[rd_idx_i];
    rd_valid_o = valid_q[rd_idx_i];
    rd_dirty_o = dirty_q[rd_idx_i];
    rd_line_o  = data_q[rd_idx_i];
  end

  // A full-line install takes precedence over a word merge; the two never coincide in practice.
  always_comb begin
    line_d = data_q[wr_idx_i];
    line_d[wr_wsel_i*DATA_W +: DATA_W] = wr_data_i;
    if (wr_line_i) line_d = wr_fill_i;
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_line_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = 1'b0;
    end else if (wr_word_i) begin
      dirty_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Data and tag arrays carry no reset; stale contents are masked by the cleared valid bits.
  always_ff @(posedge clk) begin
    if (wr_line_i || wr_word_i) data_q[wr_idx_i] <= line_d;
    if (wr_line_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

endmodule

// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with miss stall and saturating hit/miss counters.
//   state     | meaning
//   IDLE      | serve hits; classify a miss as dirty (write back first) or clean
//   WRITEBACK | victim line on the memory bus until ack
//   REFILL    | read the requested line; first cycle after a write-back keeps cs low
//   UPDATE    | install refilled line (valid, clean), then back to IDLE
module l1_dcache_dm
  import dcache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 256,
  parameter int NUM_LINES = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = calc_off_w(LINE_W);
  localparam int IDX_W  = calc_idx_w(NUM_LINES);
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_W, NUM_LINES);
  localparam int WPL    = calc_words(LINE_W, DATA_W);
  localparam int WSEL_W = calc_wsel_w(LINE_W, DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dc_state_e         state_q, state_d;
  logic              gap_q, gap_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              req, hit;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] wsel;
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_valid, lk_dirty;
  logic [LINE_W-1:0] lk_line;
  logic [DATA_W-1:0] lk_word;
  logic              st_word, st_line;
  logic [IDX_W-1:0]  st_idx;

  assign req     = cpu_rd_i | cpu_wr_i;
  assign req_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel    = (WPL > 1) ? WSEL_W'(cpu_addr_i >> 2) : '0;

  // Outside IDLE the arrays are looked up at the latched miss index so a dropped
  // or changed request cannot disturb the victim line while it is on the bus.
  assign lk_idx  = (state_q == IDLE) ? req_idx : miss_idx_q;
  assign hit     = req && (state_q == IDLE) && lk_valid && (lk_tag == req_tag);
  assign lk_word = lk_line[wsel*DATA_W +: DATA_W];

  assign cpu_data_o  = (hit && !cpu_wr_i) ? lk_word : '0;
  assign cpu_stall_o = req && !hit;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;
  assign st_idx      = st_line ? miss_idx_q : req_idx;

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .WSEL_W    (WSEL_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (lk_idx),
    .rd_tag_o   (lk_tag),
    .rd_valid_o (lk_valid),
    .rd_dirty_o (lk_dirty),
    .rd_line_o  (lk_line),
    .wr_word_i  (st_word),
    .wr_line_i  (st_line),
    .wr_idx_i   (st_idx),
    .wr_wsel_i  (wsel),
    .wr_data_i  (cpu_data_i),
    .wr_tag_i   (miss_tag_q),
    .wr_fill_i  (fill_q)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    fill_d     = fill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    st_word    = 1'b0;
    st_line    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
          st_word = cpu_wr_i;
        end else if (req) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d = (lk_valid && lk_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {lk_tag, miss_idx_q, {OFF_W{1'b0}}};
        mem_data_o = lk_line;
        if (mem_ack_i) begin
          state_d = REFILL;
          gap_d   = 1'b1;
        end
      end
      REFILL: begin
        mem_cs_o   = !gap_q;
        mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i && !gap_q) begin
          fill_d  = mem_data_i;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        st_line = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      fill_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      fill_q     <= fill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_l1_dcache_dm.sv
// Bench for l1_dcache_dm: directed scenarios plus random traffic against a flat-memory
// coherence model and a set-occupancy model, with a latency-programmable memory responder.
module tb_l1_dcache_dm;

  logic         clk, rst;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_rd_i, cpu_wr_i, cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_cs_o, mem_we_o, mem_ack_i;
  logic [3:0]   hit_cnt_o, miss_cnt_o;

  int errors, checks;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bk_mem  [int unsigned];
  bit          m_valid [32];
  bit          m_dirty [32];
  int unsigned m_tag   [32];
  int          m_hit, m_miss;

  l1_dcache_dm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bk_rd(input int unsigned wa);
    return bk_mem.exists(wa) ? bk_mem[wa] : init_word(wa);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0;
    end
    m_hit = 0; m_miss = 0;
    ref_mem = bk_mem;
  endtask

  // Predicts one access from set occupancy and the coherent memory image, then updates both.
  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                              input bit count_hit, output bit e_hit, output bit e_wb,
                              output logic [31:0] e_wb_addr, output logic [255:0] e_wb_line,
                              output logic [31:0] e_rdata);
    int unsigned idx, tg, wa;
    idx = (a >> 5) % 32; tg = a >> 10; wa = a >> 2;
    e_hit = m_valid[idx] && (m_tag[idx] == tg);
    e_wb = 0; e_wb_addr = '0; e_wb_line = '0;
    if (!e_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e_wb = 1;
        e_wb_addr = (m_tag[idx] << 10) | (idx << 5);
        for (int w = 0; w < 8; w++) e_wb_line[32*w +: 32] = ref_rd((e_wb_addr >> 2) + w);
      end
      if (m_miss < 15) m_miss++;
      m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
    end
    if (count_hit && m_hit < 15) m_hit++;
    if (wr) begin
      ref_mem[wa] = d; m_dirty[idx] = 1; e_rdata = '0;
    end else begin
      e_rdata = ref_rd(wa);
    end
  endtask

  // Drives one request from a negedge until it stops stalling, acting as the memory.
  task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                        input int lat, input bit spur,
                        output int stalls, output logic [31:0] rdata, output bit saw_wb,
                        output logic [31:0] wb_addr, output logic [255:0] wb_line,
                        output int gaps, output logic [31:0] rf_addr);
    int  cs_cnt, cyc;
    bit  done, wb_done, rf_seen;
    stalls = 0; rdata = '0; saw_wb = 0; wb_addr = '0; wb_line = '0; gaps = 0; rf_addr = '0;
    cs_cnt = 0; cyc = 0; done = 0; wb_done = 0; rf_seen = 0;
    cpu_addr_i = a; cpu_data_i = d; cpu_rd_i = rd; cpu_wr_i = wr;
    while (!done && cyc < 300) begin
      #1;
      mem_ack_i = 0; mem_data_i = '0;
      if (!cpu_stall_o) begin
        done = 1; rdata = cpu_data_o;
      end else begin
        stalls++;
        if (mem_cs_o) begin
          if (!mem_we_o) rf_seen = 1;
          cs_cnt++;
          if (cs_cnt == lat) begin
            cs_cnt = 0; mem_ack_i = 1;
            if (mem_we_o) begin
              saw_wb = 1; wb_done = 1; wb_addr = mem_addr_o; wb_line = mem_data_o;
              for (int w = 0; w < 8; w++) bk_mem[(mem_addr_o >> 2) + w] = mem_data_o[32*w +: 32];
            end else begin
              rf_addr = mem_addr_o;
              for (int w = 0; w < 8; w++) mem_data_i[32*w +: 32] = bk_rd((mem_addr_o >> 2) + w);
            end
          end
        end else if (wb_done && !rf_seen) begin
          gaps++;
          if (spur) begin mem_ack_i = 1; mem_data_i = {8{32'hBAD0_BAD0}}; end
        end
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h still stalled after %0d cycles", a, cyc);
    end
    @(negedge clk);
    cpu_rd_i = 0; cpu_wr_i = 0; mem_ack_i = 0; mem_data_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cpu_rd_i = 0; cpu_wr_i = 0; mem_ack_i = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall_o); end
    if (mem_cs_o !== 1'b0)    begin errors++; $display("FAIL reset_cs got=%b exp=0", mem_cs_o); end
    if (mem_we_o !== 1'b0)    begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
    if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    if (mem_data_o !== '0)    begin errors++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_o); end
    if (hit_cnt_o !== 4'd0 || miss_cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt_o, miss_cnt_o);
    end
    if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_data got=%h exp=0", cpu_data_o); end
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    model_access(32'h40, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h40, 1, 0, 0, 3, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 5;
    if (st != 5) begin errors++; $display("FAIL cold_stall_cycles got=%0d exp=5", st); end
    if (rd !== init_word(32'h10)) begin errors++; $display("FAIL cold_data got=%h exp=%h", rd, init_word(32'h10)); end
    if (rfa !== 32'h40) begin errors++; $display("FAIL cold_refill_addr got=%h exp=00000040", rfa); end
    if (miss_cnt_o !== 4'd1) begin errors++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt_o); end
    if (hit_cnt_o !== 4'd1) begin errors++; $display("FAIL cold_hit_cnt got=%0d exp=1", hit_cnt_o); end
  endtask

  task automatic test_write_hit();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    model_access(32'h44, 1, 32'hDEAD_BEEF, 1, eh, ew, ewa, ewl, er);
    access(32'h44, 0, 1, 32'hDEAD_BEEF, 2, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 2;
    if (st != 0) begin errors++; $display("FAIL write_hit_stall got=%0d exp=0", st); end
    if (rd !== 32'h0) begin errors++; $display("FAIL write_hit_cpu_data got=%h exp=0", rd); end
    model_access(32'h44, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h44, 1, 0, 0, 2, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 3;
    if (st != 0) begin errors++; $display("FAIL readback_stall got=%0d exp=0", st); end
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL readback_data got=%h exp=deadbeef", rd); end
    if (hit_cnt_o !== 4'(m_hit)) begin errors++; $display("FAIL readback_hit_cnt got=%0d exp=%0d", hit_cnt_o, m_hit); end
  endtask

  task automatic test_conflict_writeback();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    logic [31:0] w1;
    model_access(32'h440, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h440, 1, 0, 0, 2, 1, st, rd, sw, wa, wl, gp, rfa);
    w1 = wl[63:32];
    checks += 8;
    if (!sw) begin errors++; $display("FAIL conflict_wb_seen got=0 exp=1"); end
    if (wa !== 32'h40) begin errors++; $display("FAIL conflict_wb_addr got=%h exp=00000040", wa); end
    if (w1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL conflict_wb_word1 got=%h exp=deadbeef", w1); end
    if (wl !== ewl) begin errors++; $display("FAIL conflict_wb_line got=%h exp=%h", wl, ewl); end
    if (gp != 1) begin errors++; $display("FAIL conflict_cs_gap got=%0d exp=1", gp); end
    if (rfa !== 32'h440) begin errors++; $display("FAIL conflict_refill_addr got=%h exp=00000440", rfa); end
    if (st != 7) begin errors++; $display("FAIL conflict_stall_cycles got=%0d exp=7", st); end
    if (miss_cnt_o !== 4'd2 || rd !== er) begin
      errors++; $display("FAIL conflict_miss_cnt_data got=%0d/%h exp=2/%h", miss_cnt_o, rd, er);
    end
  endtask

  task automatic test_rd_wr_priority();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    logic [31:0] w2;
    model_access(32'h448, 1, 32'h1234_5678, 1, eh, ew, ewa, ewl, er);
    access(32'h448, 1, 1, 32'h1234_5678, 2, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 2;
    if (st != 0) begin errors++; $display("FAIL rdwr_stall got=%0d exp=0", st); end
    if (rd !== 32'h0) begin errors++; $display("FAIL rdwr_cpu_data got=%h exp=0", rd); end
    model_access(32'h48, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h48, 1, 0, 0, 1, 0, st, rd, sw, wa, wl, gp, rfa);
    w2 = wl[95:64];
    checks += 3;
    if (!sw || wa !== 32'h440) begin errors++; $display("FAIL rdwr_dirty_wb got=%b/%h exp=1/00000440", sw, wa); end
    if (w2 !== 32'h1234_5678) begin errors++; $display("FAIL rdwr_wb_word2 got=%h exp=12345678", w2); end
    if (rd !== er) begin errors++; $display("FAIL rdwr_reload_data got=%h exp=%h", rd, er); end
  endtask

  task automatic test_reset_mid_refill();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    cpu_addr_i = 32'h2060; cpu_rd_i = 1;
    @(negedge clk);
    #1;
    checks++;
    if (mem_cs_o !== 1'b1 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_refill got=cs%b/we%b exp=cs1/we0", mem_cs_o, mem_we_o);
    end
    @(negedge clk);
    rst = 1; mem_ack_i = 1; mem_data_i = {8{32'hCAFE_F00D}}; cpu_rd_i = 0;
    @(negedge clk);
    rst = 0;
    #1;
    checks += 3;
    if (mem_cs_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_cs_we got=%b/%b exp=0/0", mem_cs_o, mem_we_o);
    end
    if (mem_addr_o !== 32'h0 || mem_data_o !== '0) begin
      errors++; $display("FAIL rstmid_addr got=%h exp=0", mem_addr_o);
    end
    if (hit_cnt_o !== 4'd0 || miss_cnt_o !== 4'd0 || cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_counters got=%0d/%0d stall=%b exp=0/0/0", hit_cnt_o, miss_cnt_o, cpu_stall_o);
    end
    @(negedge clk);
    mem_ack_i = 0; mem_data_i = '0;
    #1;
    checks++;
    if (mem_cs_o !== 1'b0) begin errors++; $display("FAIL rstmid_stray_ack got=cs%b exp=cs0", mem_cs_o); end
    @(negedge clk);
    model_reset();
    model_access(32'h40, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h40, 1, 0, 0, 2, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 3;
    if (st != 4) begin errors++; $display("FAIL rstmid_remiss_stall got=%0d exp=4", st); end
    if (sw) begin errors++; $display("FAIL rstmid_no_wb got=1 exp=0"); end
    if (miss_cnt_o !== 4'd1 || hit_cnt_o !== 4'd1 || rd !== er) begin
      errors++; $display("FAIL rstmid_after got=%0d/%0d/%h exp=1/1/%h", miss_cnt_o, hit_cnt_o, rd, er);
    end
  endtask

  task automatic test_drop_request();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    int cs_cnt; bit got;
    cs_cnt = 0; got = 0; rfa = '0;
    cpu_addr_i = 32'h3080; cpu_rd_i = 1;
    #1;
    checks++;
    if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL drop_initial_stall got=%b exp=1", cpu_stall_o); end
    @(negedge clk);
    cpu_rd_i = 0;
    model_access(32'h3080, 0, 0, 0, eh, ew, ewa, ewl, er);
    for (int c = 0; c < 30 && !got; c++) begin
      #1;
      mem_ack_i = 0; mem_data_i = '0;
      if (mem_cs_o) begin
        cs_cnt++;
        if (cs_cnt == 2) begin
          got = 1; mem_ack_i = 1; rfa = mem_addr_o;
          for (int w = 0; w < 8; w++) mem_data_i[32*w +: 32] = bk_rd((mem_addr_o >> 2) + w);
        end
      end
      @(negedge clk);
    end
    mem_ack_i = 0; mem_data_i = '0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (!got || rfa !== 32'h3080) begin errors++; $display("FAIL drop_refill got=%b/%h exp=1/00003080", got, rfa); end
    if (miss_cnt_o !== 4'(m_miss) || hit_cnt_o !== 4'(m_hit)) begin
      errors++; $display("FAIL drop_counters got=%0d/%0d exp=%0d/%0d", miss_cnt_o, hit_cnt_o, m_miss, m_hit);
    end
    model_access(32'h3084, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h3084, 1, 0, 0, 2, 0, st, rd, sw, wa, wl, gp, rfa);
    checks += 2;
    if (st != 0) begin errors++; $display("FAIL drop_installed_stall got=%0d exp=0", st); end
    if (rd !== er) begin errors++; $display("FAIL drop_installed_data got=%h exp=%h", rd, er); end
  endtask

  task automatic test_random();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    logic [31:0] a, d; bit wr, rdq, spur; int lat, est;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      wr = ($urandom_range(0, 2) == 0);
      rdq = !wr || ($urandom_range(0, 1) == 1);
      d = $urandom; lat = $urandom_range(1, 4); spur = $urandom_range(0, 1);
      model_access(a, wr, d, 1, eh, ew, ewa, ewl, er);
      est = eh ? 0 : (ew ? 2*lat + 3 : lat + 2);
      access(a, rdq, wr, d, lat, spur, st, rd, sw, wa, wl, gp, rfa);
      checks += 4;
      if (st != est) begin errors++; $display("FAIL rand_stall[%0d] addr=%h got=%0d exp=%0d", i, a, st, est); end
      if (rd !== er) begin errors++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", i, a, rd, er); end
      if (sw !== ew || (ew && (wa !== ewa || wl !== ewl))) begin
        errors++; $display("FAIL rand_wb[%0d] got=%b/%h exp=%b/%h", i, sw, wa, ew, ewa);
      end
      if (hit_cnt_o !== 4'(m_hit) || miss_cnt_o !== 4'(m_miss)) begin
        errors++; $display("FAIL rand_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, hit_cnt_o, miss_cnt_o, m_hit, m_miss);
      end
    end
  endtask

  task automatic test_saturation();
    bit eh, ew; logic [31:0] ewa, er, rd, wa, rfa; logic [255:0] ewl, wl; int st, gp; bit sw;
    logic [31:0] a;
    do_reset();
    model_access(32'h40, 0, 0, 1, eh, ew, ewa, ewl, er);
    access(32'h40, 1, 0, 0, 1, 0, st, rd, sw, wa, wl, gp, rfa);
    for (int i = 0; i < 20; i++) begin
      a = 32'h40 + 32'((i % 8) * 4);
      model_access(a, 0, 0, 1, eh, ew, ewa, ewl, er);
      access(a, 1, 0, 0, 1, 0, st, rd, sw, wa, wl, gp, rfa);
    end
    checks += 2;
    if (hit_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_hit_cnt got=%0d exp=15", hit_cnt_o); end
    if (miss_cnt_o !== 4'd1) begin errors++; $display("FAIL sat_miss_cnt got=%0d exp=1", miss_cnt_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst = 1;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_rd_i = 0; cpu_wr_i = 0;
    mem_ack_i = 0; mem_data_i = '0;
    errors = 0; checks = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict_writeback();
    test_rd_wr_priority();
    test_reset_mid_refill();
    test_drop_request();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_dcache_dm.md
Name: l1_dcache_dm

Overview:
- Parametrised, direct-mapped, write-back, write-allocate L1 data cache. Sits in the MEM stage between the EX/MEM register outputs (ALU result = address, forwarded Rt = store data) and the external line-wide data memory.
- Replaces the single-cycle data ROM. Adds a pipeline-wide stall output for misses and saturating hit/miss counters.

Parameters:
- ADDR_W, 32, CPU byte-address width
- DATA_W, 32, CPU word width
- LINE_W, 256, cache line / memory bus width in bits; must be a power of two and a multiple of DATA_W
- NUM_LINES, 32, number of lines; must be a power of two ≥ 2
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_data_i  in  DATA_W  store data
- cpu_rd_i  in  1  load request
- cpu_wr_i  in  1  store request; has priority over cpu_rd_i
- cpu_data_o  out  DATA_W  load data, valid when a read hits
- cpu_stall_o  out  1  freeze PC and all pipeline registers
- mem_addr_o  out  ADDR_W  line-aligned memory address
- mem_data_o  out  LINE_W  victim line for write-back
- mem_cs_o  out  1  memory request
- mem_we_o  out  1  1 = write-back, 0 = refill read
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  memory completion, single-cycle pulse
- hit_cnt_o  out  CNT_W  hit count, saturating
- miss_cnt_o  out  CNT_W  miss count, saturating

Behaviour:
- Address split:
  - OFF_W = log2(LINE_W/8)
  - IDX_W = log2(NUM_LINES)
  - TAG_W = ADDR_W − IDX_W − OFF_W
  - word select = addr[OFF_W-1:2]
  - Defaults give 22/5/5 bits.
- A request is active when cpu_rd_i or cpu_wr_i is high. hit = req & valid[idx] & (tag[idx] == addr tag). All of these are combinational.
- Read hit: cpu_data_o shows the selected word in the same cycle, cpu_stall_o = 0. cpu_data_o = 0 whenever there is no read hit.
- Write hit: the word is merged into the line at the clock edge, dirty[idx] is set, no stall.
- Miss: cpu_stall_o rises combinationally in the same cycle. It stays high until the cycle in which the request hits.
- FSM states are IDLE, WRITEBACK, REFILL, UPDATE.
  - IDLE: on a miss with valid & dirty victim → WRITEBACK; on a miss otherwise → REFILL. miss_cnt increments once on the IDLE→non-IDLE transition. hit_cnt increments on every IDLE cycle with a hit.
  - WRITEBACK: mem_cs_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, idx, 0}, mem_data_o = victim line. Outputs are held stable until mem_ack_i is sampled high, then → REFILL.
  - REFILL: mem_cs_o = 1, mem_we_o = 0, mem_addr_o = {req tag, idx, 0}. When mem_ack_i is sampled high, mem_data_i is captured → UPDATE.
  - UPDATE: the line is written with tag, valid = 1, dirty = 0; mem_cs_o = 0 → IDLE. The request then hits on the next cycle, which gives a minimum miss penalty of ack latency + 2 cycles.
- mem_cs_o is low for at least one cycle between the write-back and refill transactions; the FSM drives it low for the first REFILL cycle after the WRITEBACK ack.
- mem_ack_i while mem_cs_o is low is ignored.
- A request dropped during a miss does not abort it. The current memory transaction completes, the line is installed, and the FSM returns to IDLE.
- The CPU holds addr, data and rd/wr stable while stalled.
- Counters saturate at 2^CNT_W − 1 and do not wrap.
- Reset, including mid-transaction:
  - Next state is IDLE; all valid and dirty bits are cleared; counters go to 0.
  - mem_cs_o, mem_we_o, mem_addr_o and mem_data_o are all 0.
  - Outstanding acks are ignored. Data array contents are don't-care.
  - cpu_stall_o follows the combinational rule, so it is 0 with no request.

Decomposition:
- Shared package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL, UPDATE);
  - functions deriving OFF_W, IDX_W and TAG_W from the parameters;
  - a localparam WORDS_PER_LINE = LINE_W/DATA_W.
- One sub-module, dcache_line_store, holds the tag, valid, dirty and data arrays. It provides a combinational read port and one synchronous write port with word-merge or full-line write, plus a synchronous valid/dirty clear.
- FSM, hit logic and counters stay in the top module.

Test Plan:
- Cold read at 0x0000_0040 with memory ack after 3 cycles → refill, then stall for 5 cycles total. Next cycle cpu_data_o = memory word 0x40, miss_cnt = 1, hit_cnt = 1.
- Write 0xDEAD_BEEF to 0x44 (hit after the warm-up above) → no stall, dirty[2] = 1. Reading 0x44 returns 0xDEADBEEF in the same cycle.
- Read 0x0000_0440 (same index 2, different tag) → WRITEBACK with mem_addr_o = 0x40 and 0xDEADBEEF in line word 1. Then cs low for one cycle, then REFILL at 0x440, miss_cnt = 2.
- Assert rst during REFILL with an ack pending → mem_cs_o = 0 next cycle. A later read at 0x40 misses: valid was cleared and counters are 0.
- Assert cpu_rd_i and cpu_wr_i together on a hit → treated as a write: line updated, dirty set.
- Run 2^CNT_W + 5 hits with CNT_W = 4 → hit_cnt_o = 15, held.
